// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared constants and state encoding for the serial subtractor
package serial_subtractor_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake and result bundle for the serial subtractor
import serial_subtractor_pkg::*;

interface serial_subtractor_if #(
    parameter int WIDTH = DATA_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b,
        input  ready, busy, done, diff, borrow, overflow, zero
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, diff, borrow, overflow, zero
    );
endinterface

// File: rtl/serial_subtractor_full_adder.sv
// rtl/serial_subtractor_full_adder.sv - one-bit full adder used as the serial bit slice
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b (as a + ~b + 1), LSB first, with start/done handshake
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] op_a_q,     op_a_d;
    logic [WIDTH-1:0] op_b_q,     op_b_d;
    logic [WIDTH-1:0] res_q,      res_d;
    logic             carry_q,    carry_d;
    logic             c_msb_in_q, c_msb_in_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] diff_q,     diff_d;
    logic             borrow_q,   borrow_d;
    logic             overflow_q, overflow_d;
    logic             zero_q,     zero_d;
    logic             ready_q,    ready_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;

    full_adder u_bit_slice (
        .a    (op_a_q[0]),
        .b    (op_b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign res_next = {fa_sum, res_q[WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_d      = res_q;
        carry_d    = carry_q;
        c_msb_in_d = c_msb_in_q;
        cnt_d      = cnt_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    op_a_d  = bus.a;
                    op_b_d  = ~bus.b;
                    res_d   = '0;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
                op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
                res_d   = res_next;
                carry_d = fa_cout;
                // Carry out of bit WIDTH-2 is the carry into the MSB, needed for signed overflow.
                if (cnt_q == CNT_PRE) begin
                    c_msb_in_d = fa_cout;
                end
                if (cnt_q == CNT_LAST) begin
                    diff_d     = res_next;
                    borrow_d   = ~fa_cout;
                    overflow_d = c_msb_in_q ^ fa_cout;
                    zero_d     = (res_next == '0);
                    cnt_d      = '0;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d != S_RUN);
        busy_d  = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            c_msb_in_q <= 1'b0;
            cnt_q      <= '0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            c_msb_in_q <= c_msb_in_d;
            cnt_q      <= cnt_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle two's-complement subtractor computing diff = a - b, one bit per clock, LSB first.
- Built around a single one-bit full_adder cell plus a carry flip-flop. The subtraction is performed as a + ~b + 1.
- Provides a low-area subtract/compare path for multi-cycle datapath operations such as division/compare helpers.
- Uses a start/done handshake with a latched result.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- ready  output  1  high when a start will be accepted (IDLE or DONE)
- busy  output  1  high while bits are being computed (RUN)
- done  output  1  single-cycle pulse; result valid
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  unsigned borrow (a < b unsigned) = ~carry-out of MSB
- overflow  output  1  signed overflow = carry-into-MSB XOR carry-out-of-MSB
- zero  output  1  diff == 0

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - ready = 1; busy = 0; done = 0.
  - diff = 0; borrow = 0; overflow = 0; zero = 0.
  - Internal shift registers, carry and bit counter are cleared.
- States and transitions:
  - IDLE: on start = 1, go to RUN.
  - RUN: stay for exactly WIDTH cycles, then go to DONE.
  - DONE: lasts one cycle. Go to RUN if start = 1, otherwise go to IDLE.
- Accept (edge E0, start = 1 and ready = 1):
  - Load opA <= a and opB <= ~b.
  - Set carry <= 1 and count <= 0.
  - Clear the result shift register.
  - diff, borrow, overflow and zero keep their previous values until the new done.
- RUN, each edge:
  - full_adder inputs are opA[0], opB[0] and carry.
  - The sum bit is shifted into the result MSB, with the result shifting right.
  - opA and opB shift right; carry <= cout; count increments.
  - When count == WIDTH-2, the current carry is saved as c_msb_in.
- Completion edge E_WIDTH (count == WIDTH-1):
  - diff <= final result; borrow <= ~cout; overflow <= c_msb_in ^ cout.
  - zero <= (final result == 0).
  - Enter DONE.
- Latency:
  - start high in cycle 0.
  - busy high in cycles 1..WIDTH.
  - done high in cycle WIDTH+1 only.
  - Outputs are stable from cycle WIDTH+1 until the next done.
- start while busy is ignored entirely. Operands are not re-sampled and the computation is unaffected.
- start during DONE is accepted, giving back-to-back operations with no bubble. done pulses every WIDTH+1 cycles under continuous start.
- a and b may change freely after acceptance.
- Reset asserted mid-RUN or during DONE:
  - Abort on that edge and go to IDLE.
  - All outputs return to reset values and no done is produced.
  - reset has priority over start.
- Width rules: all arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH) bits wide, with no wrap beyond WIDTH-1.

Decomposition:
- Shared package/include:
  - State encoding constants: S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2.
  - Default width constant DATA_WIDTH = 32.
  - Counter width CNT_W = $clog2(WIDTH).
- Sub-module: instantiate the existing full_adder cell once as the serial bit slice. All other logic stays in serial_subtractor (FSM, shift registers, flags).

Test Plan:
1. a = 5, b = 3, start one cycle -> done exactly in cycle 33; diff = 0x00000002, borrow = 0, overflow = 0, zero = 0; busy high cycles 1..32.
2. a = 3, b = 5 -> diff = 0xFFFFFFFE, borrow = 1, overflow = 0. Then a = 0x80000000, b = 1 -> diff = 0x7FFFFFFF, borrow = 0, overflow = 1.
3. a = 0x7FFFFFFF, b = 0xFFFFFFFF -> diff = 0x80000000, overflow = 1, borrow = 1. Then a = b = 0x12345678 -> diff = 0, zero = 1, borrow = 0.
4. Start a = 10, b = 4; pulse start with a = 1, b = 1 at cycle 10 -> pulse ignored; done at cycle 33 with diff = 6. Hold start high at DONE with a = 9, b = 2 -> next done at cycle 66, diff = 7.
5. Start a = 100, b = 1; assert reset at cycle 15 -> cycle 16: busy = 0, ready = 1, diff = 0, no done ever. Then start a = 2, b = 2 -> zero = 1 after 33 cycles.
6. WIDTH = 4 instance, exhaustive 256 operand pairs -> diff, borrow and overflow match a reference model; done spacing is 5 cycles.
